// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its collector peer.
// State encoding, counter sizing and chunk slicing.
`ifndef PISO_CHUNK
`define PISO_CHUNK(vec, k, w, n) vec[(w)*(n)-1-(k)*(w) -: (w)]
`endif

package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out width converter, MSB chunk first.
// Supports short words, abort and zero-bubble back-to-back words.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int N_CHUNKS = 4,
  localparam int IN_WIDTH = OUT_WIDTH * N_CHUNKS,
  localparam int CNT_WIDTH = cnt_width(N_CHUNKS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_abort,
  input  logic                 i_valid,
  input  logic [IN_WIDTH-1:0]  i_data,
  input  logic [CNT_WIDTH-1:0] i_nchunks,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_ready
);

  generate
    if (N_CHUNKS == 1) begin : g_single

      logic unused_single;
      assign unused_single = ^{i_clk, i_rst, i_nchunks};

      assign o_valid = i_valid & ~i_abort;
      assign o_data  = i_data;
      assign o_last  = o_valid;
      assign o_ready = i_ready & ~i_abort;

    end else begin : g_multi

      localparam logic [CNT_WIDTH-1:0] NMAX = CNT_WIDTH'(N_CHUNKS);
      localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

      state_t                state_q, state_d;
      logic [IN_WIDTH-1:0]   sreg_q, sreg_d;
      logic [CNT_WIDTH-1:0]  rem_q, rem_d;
      logic [CNT_WIDTH-1:0]  eff;
      logic                  rdy_en_q;
      logic                  tx_hs;
      logic                  load;

      assign eff = (i_nchunks == '0 || i_nchunks > NMAX)
                 ? NMAX : i_nchunks;

      assign o_valid = (state_q == ST_SEND);
      assign o_last  = o_valid & (rem_q == ONE);
      assign o_data  = `PISO_CHUNK(sreg_q, 0, OUT_WIDTH, N_CHUNKS);

      assign o_ready = rdy_en_q & ~i_abort
                     & (~o_valid | (i_ready & o_last));

      assign tx_hs = o_valid & i_ready;
      assign load  = i_valid & o_ready;

      // Next state: abort beats load, load beats chunk advance.
      always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        if (i_abort) begin
          state_d = ST_IDLE;
          sreg_d  = '0;
          rem_d   = '0;
        end else if (load) begin
          state_d = ST_SEND;
          sreg_d  = i_data;
          rem_d   = eff;
        end else if (tx_hs) begin
          if (o_last) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            rem_d   = '0;
          end else begin
            sreg_d = sreg_q << OUT_WIDTH;
            rem_d  = rem_q - ONE;
          end
        end
      end

      // State, shift buffer, count and ready-enable registers.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          state_q  <= ST_IDLE;
          sreg_q   <= '0;
          rem_q    <= '0;
          rdy_en_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          sreg_q   <= sreg_d;
          rem_q    <= rem_d;
          rdy_en_q <= 1'b1;
        end
      end

    end
  endgenerate

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-based chunk model checked every
// cycle, plus directed literal scenarios and a random soak.
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        ivalid;
  logic [31:0] idata;
  logic [2:0]  inch;
  logic        iready;
  logic        ordy;
  logic        ovalid;
  logic [7:0]  odata;
  logic        olast;

  int errors = 0;
  int checks = 0;

  byte unsigned pend[$];
  bit           rdy_en = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(
    .OUT_WIDTH(8),
    .N_CHUNKS (4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_abort  (abort),
    .i_valid  (ivalid),
    .i_data   (idata),
    .i_nchunks(inch),
    .o_ready  (ordy),
    .o_valid  (ovalid),
    .o_data   (odata),
    .o_last   (olast),
    .i_ready  (iready)
  );

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic logic m_ready();
    return rdy_en && !abort &&
           (pend.size() == 0 || (iready && pend.size() == 1));
  endfunction

  // Model update: words become chunk lists, handshakes pop them.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend.delete();
      rdy_en = 1'b0;
    end else begin
      bit r;
      int m;
      r = m_ready();
      if (abort) begin
        pend.delete();
      end else begin
        if (pend.size() > 0 && iready) void'(pend.pop_front());
        if (ivalid && r) begin
          m = (inch == 0 || inch > 4) ? 4 : int'(inch);
          for (int k = 0; k < m; k++)
            pend.push_back(idata[31-8*k -: 8]);
        end
      end
      rdy_en = 1'b1;
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    chk("valid", {31'd0, ovalid}, {31'd0, pend.size() > 0});
    chk("data", {24'd0, odata},
        {24'd0, (pend.size() > 0) ? pend[0] : 8'd0});
    chk("last", {31'd0, olast}, {31'd0, pend.size() == 1});
    chk("ready", {31'd0, ordy}, {31'd0, m_ready()});
  end

  task automatic send_word(input logic [31:0] d,
                           input logic [2:0] n);
    bit acc;
    ivalid = 1'b1;
    idata  = d;
    inch   = n;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = ordy;
      @(posedge clk);
      #1;
      if (acc) break;
      if (i == 49) chk("accept_timeout", 32'd0, 32'd1);
    end
    ivalid = 1'b0;
  endtask

  task automatic expect_chunk(input logic [7:0] d, input bit l);
    @(negedge clk);
    chk("chunk_valid", {31'd0, ovalid}, 32'd1);
    chk("chunk_data", {24'd0, odata}, {24'd0, d});
    chk("chunk_last", {31'd0, olast}, {31'd0, l});
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle();
    @(negedge clk);
    chk("idle_valid", {31'd0, ovalid}, 32'd0);
    chk("idle_data", {24'd0, odata}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    abort  = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    inch   = '0;
    iready = 1'b1;

    @(negedge clk);
    chk("rst_ready", {31'd0, ordy}, 32'd0);
    chk("rst_valid", {31'd0, ovalid}, 32'd0);
    chk("rst_data", {24'd0, odata}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_rst", {31'd0, ordy}, 32'd1);

    // full word, no backpressure
    send_word(32'hAABBCCDD, 3'd0);
    expect_chunk(8'hAA, 0);
    expect_chunk(8'hBB, 0);
    expect_chunk(8'hCC, 0);
    expect_chunk(8'hDD, 1);
    expect_idle();
    @(posedge clk); #1;

    // backpressure on BB
    send_word(32'hAABBCCDD, 3'd4);
    expect_chunk(8'hAA, 0);
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", {24'd0, odata}, 32'hBB);
      chk("bp_valid", {31'd0, ovalid}, 32'd1);
      chk("bp_ready", {31'd0, ordy}, 32'd0);
      @(posedge clk); #1;
    end
    iready = 1'b1;
    expect_chunk(8'hBB, 0);
    expect_chunk(8'hCC, 0);
    expect_chunk(8'hDD, 1);

    // back-to-back words with i_valid held
    send_word(32'h01020304, 3'd0);
    ivalid = 1'b1;
    idata  = 32'h05060708;
    expect_chunk(8'h01, 0);
    expect_chunk(8'h02, 0);
    expect_chunk(8'h03, 0);
    @(negedge clk);
    chk("b2b_04", {24'd0, odata}, 32'h04);
    chk("b2b_last", {31'd0, olast}, 32'd1);
    chk("b2b_ready", {31'd0, ordy}, 32'd1);
    @(posedge clk); #1;
    ivalid = 1'b0;
    expect_chunk(8'h05, 0);
    expect_chunk(8'h06, 0);
    expect_chunk(8'h07, 0);
    expect_chunk(8'h08, 1);

    // short word
    send_word(32'h11223344, 3'd2);
    expect_chunk(8'h11, 0);
    expect_chunk(8'h22, 1);
    expect_idle();
    @(posedge clk); #1;

    // abort while CC pending
    send_word(32'hAABBCCDD, 3'd0);
    expect_chunk(8'hAA, 0);
    expect_chunk(8'hBB, 0);
    abort  = 1'b1;
    ivalid = 1'b1;
    idata  = 32'h12345678;
    @(negedge clk);
    chk("abort_ready", {31'd0, ordy}, 32'd0);
    @(posedge clk); #1;
    abort  = 1'b0;
    ivalid = 1'b0;
    expect_idle();
    @(posedge clk); #1;
    send_word(32'hDEADBEEF, 3'd0);
    expect_chunk(8'hDE, 0);
    expect_chunk(8'hAD, 0);
    expect_chunk(8'hBE, 0);
    expect_chunk(8'hEF, 1);

    // async reset mid-word
    send_word(32'hAABBCCDD, 3'd0);
    expect_chunk(8'hAA, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ovalid}, 32'd0);
    chk("arst_data", {24'd0, odata}, 32'd0);
    chk("arst_last", {31'd0, olast}, 32'd0);
    chk("arst_ready", {31'd0, ordy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(32'hAABBCCDD, 3'd0);
    expect_chunk(8'hAA, 0);
    expect_chunk(8'hBB, 0);
    expect_chunk(8'hCC, 0);
    expect_chunk(8'hDD, 1);

    // random soak, checked by the model every cycle
    for (int c = 0; c < 400; c++) begin
      ivalid = ($urandom_range(0, 1) == 1);
      idata  = $urandom;
      inch   = 3'($urandom_range(0, 7));
      iready = ($urandom_range(0, 3) != 0);
      abort  = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    ivalid = 1'b0;
    abort  = 1'b0;
    iready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
